temp_alarm_ctrl: RTL and testbench

Parametrised successor of the single-channel temperature state classifier. It takes BCD temperature and rate-of-change samples and produces the NORMAL/BORDER/WARNING/EMERGENCY state plus the LED alarm pattern. It adds entry/exit hysteresis thresholds, N-sample de-escalation filtering, a latched EMERGENCY with operator acknowledge, a blinking WARNING pattern and invalid-BCD rejection. It sits between the BCD conversion/difference logic and the LED/7-seg drivers, in the single system clock domain.

---
 rtl/temp_alarm_ctrl_pkg.sv | 39 +++
 rtl/temp_alarm_ctrl_bcd_level_classify.sv | 44 ++++
 rtl/temp_alarm_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_temp_alarm_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/temp_alarm_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : temp_alarm_ctrl_pkg
//  Purpose  : Shared state codes, alarm LED patterns and helpers for the
//             temperature alarm controller and its level classifier.
//  Contents : state_t (NORMAL=1 .. EMERGENCY=4), STATE_W, ALARM_OFF,
//             ALARM_ALL, alarm_alt() for the blinking WARNING pattern.
//  Revision : 1.0  initial release
// ============================================================================
package temp_alarm_ctrl_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_NORMAL    = 3'd1,
    ST_BORDER    = 3'd2,
    ST_WARNING   = 3'd3,
    ST_EMERGENCY = 3'd4
  } state_t;

  // Patterns are held at the widest supported LED bus and truncated by users.
  localparam int          ALARM_MAX_W = 64;
  localparam logic [63:0] ALARM_OFF   = '0;
  localparam logic [63:0] ALARM_ALL   = '1;

  // Alternating pattern of the given width with its MSB set (1010...).
  function automatic logic [63:0] alarm_alt(input int width);
    logic [63:0] p;
    p = '0;
    for (int i = 0; i < ALARM_MAX_W; i++) begin
      if (i < width) begin
        if (((width - 1 - i) % 2) == 0) p[i] = 1'b1;
      end
    end
    return p;
  endfunction

endpackage : temp_alarm_ctrl_pkg
`default_nettype wire

// File: rtl/temp_alarm_ctrl_bcd_level_classify.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_level_classify
//  Purpose  : Combinational classification of a packed BCD value against
//             three ascending thresholds, plus a digit-validity flag.
//  Ports    : value_i      packed BCD value (4*DIGITS bits)
//             th_lo_i      BORDER threshold
//             th_mid_i     WARNING threshold
//             th_hi_i      EMERGENCY threshold
//             level_o      NORMAL/BORDER/WARNING/EMERGENCY
//             digits_ok_o  1 when every nibble of value_i is 0..9
//  Revision : 1.0  initial release
// ============================================================================
module bcd_level_classify
  import temp_alarm_ctrl_pkg::*;
#(
  parameter int DIGITS = 3
) (
  input  logic [4*DIGITS-1:0] value_i,
  input  logic [4*DIGITS-1:0] th_lo_i,
  input  logic [4*DIGITS-1:0] th_mid_i,
  input  logic [4*DIGITS-1:0] th_hi_i,
  output state_t              level_o,
  output logic                digits_ok_o
);

  logic [DIGITS-1:0] w_dig_ok;

  for (genvar d = 0; d < DIGITS; d++) begin : g_digit
    assign w_dig_ok[d] = (value_i[4*d +: 4] <= 4'd9);
  end

  assign digits_ok_o = &w_dig_ok;

  // Valid packed BCD orders identically to its unsigned binary reading.
  always_comb begin
    if (value_i < th_lo_i)       level_o = ST_NORMAL;
    else if (value_i < th_mid_i) level_o = ST_BORDER;
    else if (value_i < th_hi_i)  level_o = ST_WARNING;
    else                         level_o = ST_EMERGENCY;
  end

endmodule : bcd_level_classify
`default_nettype wire

// File: rtl/temp_alarm_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : temp_alarm_ctrl
//  Purpose  : Temperature state classifier with entry/exit hysteresis,
//             N-sample de-escalation, latched EMERGENCY with acknowledge,
//             blinking WARNING LED pattern and invalid-BCD rejection.
//  Ports    : clk, rst             clock, synchronous active-high reset
//             sample_valid_i       strobe qualifying temp/diff/diff_valid
//             temp_bcd_i           packed BCD temperature
//             diff_bcd_i           packed BCD change magnitude
//             diff_valid_i         diff_bcd_i meaningful for this sample
//             sign_changed_i       sign-mode change pulse (latch cause)
//             ack_i                operator acknowledge of the latch
//             state_o              1=NORMAL 2=BORDER 3=WARNING 4=EMERGENCY
//             alarm_o              LED pattern
//             latched_o            EMERGENCY latched
//             state_chg_o          pulse with every state change
//             bcd_err_o            pulse when a sample is rejected
//  Revision : 1.0  initial release
// ============================================================================
module temp_alarm_ctrl
  import temp_alarm_ctrl_pkg::*;
#(
  parameter int                DIGITS       = 3,
  parameter int                LED_W        = 10,
  parameter logic [4*DIGITS-1:0] BORDER_IN  = 12'h400,
  parameter logic [4*DIGITS-1:0] WARN_IN    = 12'h470,
  parameter logic [4*DIGITS-1:0] EMER_IN    = 12'h500,
  parameter logic [4*DIGITS-1:0] BORDER_OUT = 12'h380,
  parameter logic [4*DIGITS-1:0] WARN_OUT   = 12'h450,
  parameter logic [4*DIGITS-1:0] EMER_OUT   = 12'h480,
  parameter logic [4*DIGITS-1:0] RATE_TH    = 12'h050,
  parameter int                HOLD_SAMPLES = 4,
  parameter int                BLINK_DIV    = 25000000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sample_valid_i,
  input  logic [4*DIGITS-1:0] temp_bcd_i,
  input  logic [4*DIGITS-1:0] diff_bcd_i,
  input  logic                diff_valid_i,
  input  logic                sign_changed_i,
  input  logic                ack_i,
  output logic [STATE_W-1:0]  state_o,
  output logic [LED_W-1:0]    alarm_o,
  output logic                latched_o,
  output logic                state_chg_o,
  output logic                bcd_err_o
);

  localparam int CNT_W = $clog2(HOLD_SAMPLES + 1);
  localparam int BLK_W = $clog2(BLINK_DIV);

  localparam logic [CNT_W-1:0] C_HOLD     = CNT_W'(HOLD_SAMPLES);
  localparam logic [BLK_W-1:0] C_BLK_LAST = BLK_W'(BLINK_DIV - 1);
  localparam logic [LED_W-1:0] C_ALT      = LED_W'(alarm_alt(LED_W));
  localparam logic [LED_W-1:0] C_ALL      = LED_W'(ALARM_ALL);
  localparam logic [LED_W-1:0] C_OFF      = LED_W'(ALARM_OFF);

  state_t             state_q,   state_d;
  logic [LED_W-1:0]   alarm_q,   alarm_d;
  logic               latched_q, latched_d;
  logic               chg_q,     chg_d;
  logic               err_q,     err_d;
  logic [CNT_W-1:0]   cnt_q,     cnt_d;
  logic [BLK_W-1:0]   blk_cnt_q, blk_cnt_d;
  logic               phase_q,   phase_d;

  state_t             w_entry_cls, w_entry_lvl, w_exit_lvl;
  logic               w_ent_ok, w_ext_ok, w_temp_ok, w_diff_ok;
  logic [4*DIGITS-1:0] w_diff_dig_ok_unused;
  logic [DIGITS-1:0]  w_diff_dig_ok;
  logic               w_valid, w_rate_cause, w_set, w_blocked;
  logic [CNT_W-1:0]   w_cnt_base, w_cnt_inc;

  bcd_level_classify #(.DIGITS(DIGITS)) u_entry (
    .value_i     (temp_bcd_i),
    .th_lo_i     (BORDER_IN),
    .th_mid_i    (WARN_IN),
    .th_hi_i     (EMER_IN),
    .level_o     (w_entry_cls),
    .digits_ok_o (w_ent_ok)
  );

  bcd_level_classify #(.DIGITS(DIGITS)) u_exit (
    .value_i     (temp_bcd_i),
    .th_lo_i     (BORDER_OUT),
    .th_mid_i    (WARN_OUT),
    .th_hi_i     (EMER_OUT),
    .level_o     (w_exit_lvl),
    .digits_ok_o (w_ext_ok)
  );

  for (genvar d = 0; d < DIGITS; d++) begin : g_diff_digit
    assign w_diff_dig_ok[d] = (diff_bcd_i[4*d +: 4] <= 4'd9);
  end
  assign w_diff_dig_ok_unused = '0;

  assign w_temp_ok = w_ent_ok & w_ext_ok;
  assign w_diff_ok = &w_diff_dig_ok;
  assign w_valid   = sample_valid_i & w_temp_ok & (~diff_valid_i | w_diff_ok);

  // A fast rise forces EMERGENCY regardless of the absolute temperature.
  assign w_rate_cause = w_valid & diff_valid_i & (diff_bcd_i >= RATE_TH);
  assign w_entry_lvl  = w_rate_cause ? ST_EMERGENCY : w_entry_cls;

  assign w_set     = sign_changed_i | w_rate_cause;
  assign w_blocked = latched_q | w_set;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_NORMAL;
      alarm_q   <= '0;
      latched_q <= 1'b0;
      chg_q     <= 1'b0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
      blk_cnt_q <= '0;
      phase_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      alarm_q   <= alarm_d;
      latched_q <= latched_d;
      chg_q     <= chg_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
      blk_cnt_q <= blk_cnt_d;
      phase_q   <= phase_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    latched_d  = latched_q;
    blk_cnt_d  = '0;
    phase_d    = 1'b0;
    alarm_d    = C_OFF;
    err_d      = sample_valid_i & ~w_valid;
    // An accepted acknowledge restarts the de-escalation count, so samples
    // seen while latched never shorten the hold afterwards.
    w_cnt_base = (ack_i & latched_q & ~w_set) ? '0 : cnt_q;
    w_cnt_inc  = (w_cnt_base == C_HOLD) ? C_HOLD : w_cnt_base + CNT_W'(1);
    cnt_d      = w_cnt_base;

    if (w_valid) begin
      if (w_entry_lvl > state_q) begin
        state_d = w_entry_lvl;
        cnt_d   = '0;
      end else if (w_exit_lvl < state_q) begin
        // Count saturates while blocked; it is only consumed once unlatched.
        if ((w_cnt_inc == C_HOLD) && !w_blocked) begin
          state_d = w_exit_lvl;
          cnt_d   = '0;
        end else begin
          cnt_d = w_cnt_inc;
        end
      end else begin
        cnt_d = '0;
      end
    end

    if (w_rate_cause || (sign_changed_i && !w_valid)) cnt_d = '0;

    // Setting the latch wins over an acknowledge in the same cycle.
    if (w_set) begin
      state_d   = ST_EMERGENCY;
      latched_d = 1'b1;
    end else if (ack_i) begin
      latched_d = 1'b0;
    end

    case (state_d)
      ST_WARNING: begin
        if (state_q == ST_WARNING) begin
          if (blk_cnt_q == C_BLK_LAST) begin
            phase_d = ~phase_q;
          end else begin
            blk_cnt_d = blk_cnt_q + BLK_W'(1);
            phase_d   = phase_q;
          end
        end
        alarm_d = phase_d ? ~C_ALT : C_ALT;
      end
      ST_EMERGENCY: alarm_d = C_ALL;
      default:      alarm_d = C_OFF;
    endcase

    chg_d = (state_d != state_q);
  end

  assign state_o     = state_q;
  assign alarm_o     = alarm_q;
  assign latched_o   = latched_q;
  assign state_chg_o = chg_q;
  assign bcd_err_o   = err_q;

endmodule : temp_alarm_ctrl
`default_nettype wire

// File: tb/tb_temp_alarm_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_temp_alarm_ctrl
//  Purpose  : Self-checking bench for temp_alarm_ctrl: behavioural model
//             compared every cycle plus directed literal expectations.
//  Revision : 1.0  initial release
// ============================================================================
module tb_temp_alarm_ctrl;

  localparam int BLINK = 4;
  localparam int HOLD  = 4;
  localparam logic [9:0] ALT  = 10'h2AA;
  localparam logic [9:0] ALTN = 10'h155;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sv = 1'b0, dv = 1'b0, sc = 1'b0, ack = 1'b0;
  logic [11:0] temp = '0, diff = '0;
  logic [2:0]  state;
  logic [9:0]  alarm;
  logic        latched, chg, err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  temp_alarm_ctrl #(
    .BLINK_DIV    (BLINK),
    .HOLD_SAMPLES (HOLD)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .sample_valid_i (sv),
    .temp_bcd_i     (temp),
    .diff_bcd_i     (diff),
    .diff_valid_i   (dv),
    .sign_changed_i (sc),
    .ack_i          (ack),
    .state_o        (state),
    .alarm_o        (alarm),
    .latched_o      (latched),
    .state_chg_o    (chg),
    .bcd_err_o      (err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int         m_state = 1, m_cnt = 0, m_wk = 0;
  bit         m_lat = 0, m_chg = 0, m_err = 0;
  logic [9:0] m_alarm = '0;

  function automatic bit bcd_ok(input logic [11:0] v);
    for (int d = 0; d < 3; d++)
      if (((v >> (4*d)) & 12'hF) > 12'd9) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int level(input int v, input int a, input int b, input int c);
    if (v < a) return 1;
    if (v < b) return 2;
    if (v < c) return 3;
    return 4;
  endfunction

  always @(posedge clk) begin
    int  nxt, ent, ext;
    bit  valid, rate, setc;
    if (rst) begin
      m_state = 1; m_cnt = 0; m_wk = 0; m_lat = 0; m_chg = 0; m_err = 0; m_alarm = '0;
    end else begin
      valid = sv && bcd_ok(temp) && (!dv || bcd_ok(diff));
      m_err = sv && !valid;
      rate  = valid && dv && (int'(diff) >= 'h050);
      setc  = sc || rate;
      nxt   = m_state;
      if (ack && m_lat && !setc) m_cnt = 0;
      if (valid) begin
        ent = rate ? 4 : level(int'(temp), 'h400, 'h470, 'h500);
        ext = level(int'(temp), 'h380, 'h450, 'h480);
        if (ent > m_state) begin
          nxt = ent; m_cnt = 0;
        end else if (ext < m_state) begin
          m_cnt = (m_cnt + 1 > HOLD) ? HOLD : m_cnt + 1;
          if (m_cnt == HOLD && !m_lat && !setc) begin
            nxt = ext; m_cnt = 0;
          end
        end else begin
          m_cnt = 0;
        end
      end
      if (rate || (sc && !valid)) m_cnt = 0;
      if (setc) begin
        nxt = 4; m_lat = 1;
      end else if (ack) begin
        m_lat = 0;
      end
      m_chg = (nxt != m_state);
      if (nxt == 3) m_wk = (m_state == 3) ? m_wk + 1 : 0;
      m_state = nxt;
      case (m_state)
        3:       m_alarm = (((m_wk / BLINK) % 2) == 0) ? ALT : ALTN;
        4:       m_alarm = 10'h3FF;
        default: m_alarm = '0;
      endcase
    end
  end

  always @(posedge clk) begin
    #1;
    check("m_state",   {29'd0, state},   m_state);
    check("m_alarm",   {22'd0, alarm},   {22'd0, m_alarm});
    check("m_latched", {31'd0, latched}, {31'd0, m_lat});
    check("m_chg",     {31'd0, chg},     {31'd0, m_chg});
    check("m_err",     {31'd0, err},     {31'd0, m_err});
  end

  // ---------------- stimulus ----------------
  task automatic sample(input logic [11:0] t, input logic d_v = 1'b0, input logic [11:0] d = 12'h000);
    @(negedge clk); sv = 1'b1; temp = t; dv = d_v; diff = d;
    @(negedge clk); sv = 1'b0; dv = 1'b0;
  endtask

  task automatic pulse(input logic do_sc, input logic do_ack);
    @(negedge clk); sc = do_sc; ack = do_ack;
    @(negedge clk); sc = 1'b0; ack = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    idle(3);
    rst = 1'b0;
    check("reset_state", {29'd0, state}, 1);
    check("reset_alarm", {22'd0, alarm}, 0);
    check("reset_latched", {31'd0, latched}, 0);

    sample(12'h395);
    check("normal_395", {29'd0, state}, 1);
    check("nochg_395", {31'd0, chg}, 0);
    sample(12'h405);
    check("border_405", {29'd0, state}, 2);
    check("chg_405", {31'd0, chg}, 1);

    sample(12'h475);
    check("warn_475", {29'd0, state}, 3);
    check("blink_p0", {22'd0, alarm}, 32'h2AA);
    idle(3);
    check("blink_p0_end", {22'd0, alarm}, 32'h2AA);
    idle(1);
    check("blink_p1", {22'd0, alarm}, 32'h155);
    idle(4);
    check("blink_p0_again", {22'd0, alarm}, 32'h2AA);

    sample(12'h510);
    check("emer_510", {29'd0, state}, 4);
    check("emer_alarm", {22'd0, alarm}, 32'h3FF);
    check("emer_unlatched", {31'd0, latched}, 0);

    repeat (3) sample(12'h475);
    check("emer_hold3", {29'd0, state}, 4);
    sample(12'h475);
    check("emer_to_warn", {29'd0, state}, 3);

    repeat (2) sample(12'h440);
    sample(12'h460);
    check("warn_460", {29'd0, state}, 3);
    repeat (3) sample(12'h440);
    check("warn_440x3", {29'd0, state}, 3);
    sample(12'h440);
    check("warn_to_border", {29'd0, state}, 2);

    sample(12'h300, 1'b1, 12'h055);
    check("rate_emer", {29'd0, state}, 4);
    check("rate_latched", {31'd0, latched}, 1);
    repeat (6) sample(12'h300);
    check("latched_hold", {29'd0, state}, 4);
    pulse(1'b0, 1'b1);
    check("ack_unlatch", {31'd0, latched}, 0);
    check("ack_state", {29'd0, state}, 4);
    repeat (3) sample(12'h300);
    check("post_ack_x3", {29'd0, state}, 4);
    sample(12'h300);
    check("post_ack_normal", {29'd0, state}, 1);

    pulse(1'b1, 1'b0);
    check("sign_emer", {29'd0, state}, 4);
    check("sign_latched", {31'd0, latched}, 1);
    pulse(1'b1, 1'b1);
    check("sign_ack_latched", {31'd0, latched}, 1);
    pulse(1'b0, 1'b1);
    repeat (4) sample(12'h475);
    check("warn_before_rst", {29'd0, state}, 3);
    idle(2);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check("rst_state", {29'd0, state}, 1);
    check("rst_alarm", {22'd0, alarm}, 0);
    check("rst_chg", {31'd0, chg}, 0);

    sample(12'h405);
    repeat (2) sample(12'h300);
    sample(12'h4A0);
    check("bcd_err_temp", {31'd0, err}, 1);
    check("bcd_err_state", {29'd0, state}, 2);
    sample(12'h300);
    check("cnt_kept_3", {29'd0, state}, 2);
    sample(12'h300);
    check("cnt_kept_4", {29'd0, state}, 1);
    sample(12'h300, 1'b1, 12'h0A0);
    check("bcd_err_diff", {31'd0, err}, 1);
    sample(12'h200, 1'b0, 12'hFFF);
    check("diff_ignored_err", {31'd0, err}, 0);
    check("diff_ignored_state", {29'd0, state}, 1);

    idle(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_temp_alarm_ctrl
`default_nettype wire
